// File: rtl/arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_if
// Purpose  : Stream bus between NCH producers, the arb_mux and one consumer.
//            Carries in_last only when ARB_MUX_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface arb_mux_if #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
);
   localparam int SELW = $clog2(NCH);

   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
`ifdef ARB_MUX_LOCK_EN
   logic [NCH-1:0]       in_last;
`endif
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready;

   modport slave (
`ifdef ARB_MUX_LOCK_EN
      input  in_last,
`endif
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

   modport master (
`ifdef ARB_MUX_LOCK_EN
      output in_last,
`endif
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux
// Purpose  : N-channel registered stream mux, explicit-select or round-robin.
//            Optional packet lock enabled by defining ARB_MUX_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   arb_mux_if.slave    bus
);
   localparam int SELW = $clog2(NCH);

   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_out_data;
   logic [SELW-1:0]      r_out_ch;
   logic [SELW-1:0]      r_rr_ptr;

   logic                 w_can_load;
   logic                 w_xfer;
   logic [NCH-1:0]       w_grant;
   logic                 w_found;
   logic [SELW-1:0]      w_idx;
   logic [SELW-1:0]      w_ch;
   logic [WIDTH-1:0]     w_data;

`ifdef ARB_MUX_LOCK_EN
   typedef enum logic [0:0] {
      S_OPEN   = 1'b0,
      S_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t          r_lock_state;
   lock_state_t          w_lock_next;
   logic [SELW-1:0]      r_lock_ch;
   logic [SELW-1:0]      w_lock_ch_next;
`endif

   assign w_can_load = !r_out_valid || bus.out_ready;

   // Rotating search begins one past the last round-robin winner.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      w_idx   = '0;
`ifdef ARB_MUX_LOCK_EN
      if (r_lock_state == S_LOCKED) begin
         for (int i = 0; i < NCH; i++) begin
            if (r_lock_ch == SELW'(i)) w_grant[i] = bus.in_valid[i];
         end
      end else
`endif
      if (!bus.mode) begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.sel == SELW'(i)) w_grant[i] = bus.in_valid[i];
         end
      end else begin
         for (int k = 1; k <= NCH; k++) begin
            w_idx = SELW'((int'(r_rr_ptr) + k) % NCH);
            if (!w_found && bus.in_valid[w_idx]) begin
               w_grant[w_idx] = 1'b1;
               w_found        = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_ch   = '0;
      w_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant[i]) begin
            w_ch   = SELW'(i);
            w_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_xfer       = w_can_load && (|w_grant);
   assign bus.in_ready = w_grant & {NCH{w_can_load}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_rr_ptr    <= SELW'(NCH - 1);
      end else if (w_can_load) begin
         r_out_valid <= w_xfer;
         if (w_xfer) begin
            r_out_data <= w_data;
            r_out_ch   <= w_ch;
            if (bus.mode) r_rr_ptr <= w_ch;
         end
      end
   end

`ifdef ARB_MUX_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_state <= S_OPEN;
         r_lock_ch    <= '0;
      end else begin
         r_lock_state <= w_lock_next;
         r_lock_ch    <= w_lock_ch_next;
      end
   end

   // A beat without in_last pins the grant to its channel until the packet ends.
   always_comb begin
      w_lock_next    = r_lock_state;
      w_lock_ch_next = r_lock_ch;
      if (w_xfer) begin
         if (bus.in_last[w_ch]) begin
            w_lock_next = S_OPEN;
         end else begin
            w_lock_next    = S_LOCKED;
            w_lock_ch_next = w_ch;
         end
      end
   end
`endif

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;

endmodule
`default_nettype wire
